fft_bfly_engine: RTL and testbench

Iterative radix-2 decimation-in-time FFT core that consumes the per-stage butterfly index schedule (pairs `l+j`, `l+j+2^stage`, grouped as in the FFT index-ordering step) and executes it on an internal in-place complex sample buffer. It accepts SAMPLES complex samples in bit-reversed order over a valid/ready stream, runs log2(SAMPLES) stages at one butterfly per cycle, and streams out the results in natural order. Twiddle factors come from an external combinational ROM port.

---
 rtl/fft_bfly_if.sv | 27 ++
 rtl/fft_bfly_engine.sv | 177 +++++++++++++++++
 tb/tb_fft_bfly_engine.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/fft_bfly_if.sv
// Sample stream bundle for the FFT butterfly engine: bit-reversed input stream
// and natural-order output stream, both valid/ready.
interface fft_bfly_if #(
  parameter int unsigned WIDTH = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_re;
  logic signed [WIDTH-1:0] in_im;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_re;
  logic signed [WIDTH-1:0] out_im;
  logic                    out_last;

  // Core side.
  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_last
  );

  // Producer/consumer side.
  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_last
  );
endinterface

// File: rtl/fft_bfly_engine.sv
// Iterative radix-2 DIT FFT: load bit-reversed samples, run log2(SAMPLES) stages at one
// in-place butterfly per cycle, then stream results out in natural order.
module fft_bfly_engine #(
  parameter int unsigned SAMPLES = 8,
  parameter int unsigned WIDTH   = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  fft_bfly_if.slave                      bus,
  output logic                           busy,
  output logic [$clog2(SAMPLES)-1:0]     stage,
  output logic [$clog2(SAMPLES)-2:0]     tw_idx,
  input  logic signed [WIDTH-1:0]        tw_re,
  input  logic signed [WIDTH-1:0]        tw_im
);

  localparam int unsigned LG = $clog2(SAMPLES);

  localparam logic [1:0] StLoad    = 2'd0;
  localparam logic [1:0] StCompute = 2'd1;
  localparam logic [1:0] StOutput  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [LG-1:0] wr_ptr_q, wr_ptr_d;
  logic [LG-1:0] rd_ptr_q, rd_ptr_d;
  logic [LG-1:0] j_q, j_d;
  logic [LG-1:0] l_q, l_d;
  logic [LG-1:0] stage_q, stage_d;
  logic          rdy_en_q;

  logic signed [WIDTH-1:0] buf_re_q [SAMPLES];
  logic signed [WIDTH-1:0] buf_im_q [SAMPLES];

  logic          in_ready, in_hs, out_valid;
  logic [LG-1:0] half, a_idx, b_idx, tw_full, tw_shamt;
  logic [LG:0]   l_next;
  logic          last_j, last_grp;

  logic signed [WIDTH-1:0]   a_re, a_im, b_re, b_im, t_re, t_im;
  logic signed [2*WIDTH-1:0] p_re, p_im;
  logic signed [WIDTH:0]     s_re, s_im, d_re, d_im;

  // Butterfly addressing and twiddle index.
  always_comb begin
    half     = LG'(1) << stage_q;
    a_idx    = l_q + j_q;
    b_idx    = a_idx + half;
    tw_shamt = LG'(LG - 1) - stage_q;
    tw_full  = j_q << tw_shamt;
    l_next   = {1'b0, l_q} + {half, 1'b0};
    last_j   = (j_q == half - LG'(1));
    last_grp = (l_next == (LG+1)'(SAMPLES));
  end

  always_comb begin
    a_re = buf_re_q[a_idx];
    a_im = buf_im_q[a_idx];
    b_re = buf_re_q[b_idx];
    b_im = buf_im_q[b_idx];
    p_re = (2*WIDTH)'(b_re) * (2*WIDTH)'(tw_re) - (2*WIDTH)'(b_im) * (2*WIDTH)'(tw_im);
    p_im = (2*WIDTH)'(b_re) * (2*WIDTH)'(tw_im) + (2*WIDTH)'(b_im) * (2*WIDTH)'(tw_re);
    // W^0 skips the multiplier so the unity twiddle does not lose an LSB.
    if (tw_full == '0) begin
      t_re = b_re;
      t_im = b_im;
    end else begin
      t_re = p_re[2*WIDTH-2:WIDTH-1];
      t_im = p_im[2*WIDTH-2:WIDTH-1];
    end
    s_re = {a_re[WIDTH-1], a_re} + {t_re[WIDTH-1], t_re};
    s_im = {a_im[WIDTH-1], a_im} + {t_im[WIDTH-1], t_im};
    d_re = {a_re[WIDTH-1], a_re} - {t_re[WIDTH-1], t_re};
    d_im = {a_im[WIDTH-1], a_im} - {t_im[WIDTH-1], t_im};
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    j_d      = j_q;
    l_d      = l_q;
    stage_d  = stage_q;
    case (state_q)
      StLoad: begin
        if (in_hs) begin
          wr_ptr_d = wr_ptr_q + LG'(1);
          if (wr_ptr_q == LG'(SAMPLES - 1)) begin
            state_d  = StCompute;
            wr_ptr_d = '0;
            stage_d  = '0;
            j_d      = '0;
            l_d      = '0;
          end
        end
      end
      StCompute: begin
        if (!last_j) begin
          j_d = j_q + LG'(1);
        end else begin
          j_d = '0;
          if (!last_grp) begin
            l_d = l_next[LG-1:0];
          end else begin
            l_d = '0;
            if (stage_q == LG'(LG - 1)) begin
              state_d  = StOutput;
              rd_ptr_d = '0;
            end else begin
              stage_d = stage_q + LG'(1);
            end
          end
        end
      end
      StOutput: begin
        if (bus.out_ready) begin
          rd_ptr_d = rd_ptr_q + LG'(1);
          if (rd_ptr_q == LG'(SAMPLES - 1)) begin
            state_d  = StLoad;
            rd_ptr_d = '0;
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StLoad;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      j_q      <= '0;
      l_q      <= '0;
      stage_q  <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      j_q      <= j_d;
      l_q      <= l_d;
      stage_q  <= stage_d;
      rdy_en_q <= 1'b1;
    end
  end

  // Sample buffer carries no reset; an aborted block's contents are simply overwritten.
  always_ff @(posedge clk) begin
    if (in_hs) begin
      buf_re_q[wr_ptr_q] <= bus.in_re;
      buf_im_q[wr_ptr_q] <= bus.in_im;
    end else if (busy) begin
      buf_re_q[a_idx] <= s_re[WIDTH:1];
      buf_im_q[a_idx] <= s_im[WIDTH:1];
      buf_re_q[b_idx] <= d_re[WIDTH:1];
      buf_im_q[b_idx] <= d_im[WIDTH:1];
    end
  end

  // in_ready stays low until the first clock edge after reset release.
  assign in_ready      = (state_q == StLoad) && rdy_en_q;
  assign in_hs         = in_ready && bus.in_valid;
  assign out_valid     = (state_q == StOutput);
  assign busy          = (state_q == StCompute);
  assign stage         = stage_q;
  assign tw_idx        = busy ? tw_full[LG-2:0] : '0;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_re    = out_valid ? buf_re_q[rd_ptr_q] : '0;
  assign bus.out_im    = out_valid ? buf_im_q[rd_ptr_q] : '0;
  assign bus.out_last  = out_valid && (rd_ptr_q == LG'(SAMPLES - 1));

  logic unused_bits;
  assign unused_bits = ^{p_re[2*WIDTH-1], p_re[WIDTH-2:0], p_im[2*WIDTH-1], p_im[WIDTH-2:0],
                         s_re[0], s_im[0], d_re[0], d_im[0], tw_full[LG-1]};

endmodule

// File: tb/tb_fft_bfly_engine.sv
// Directed bench for fft_bfly_engine (SAMPLES=8, WIDTH=16): table of blocks with
// hand-computed spectra, plus backpressure and mid-compute reset sequences.
module tb_fft_bfly_engine;
  localparam int unsigned N = 8;
  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_bfly_if #(.WIDTH(W)) bus ();
  logic                busy;
  logic [2:0]          stage;
  logic [1:0]          tw_idx;
  logic signed [W-1:0] tw_re, tw_im;

  fft_bfly_engine #(.SAMPLES(N), .WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .busy   (busy),
    .stage  (stage),
    .tw_idx (tw_idx),
    .tw_re  (tw_re),
    .tw_im  (tw_im)
  );

  // Twiddle ROM, Q1.15: W^k = exp(-j*2*pi*k/8).
  always_comb begin
    tw_re = 16'sd32767;
    tw_im = 16'sd0;
    case (tw_idx)
      2'd1: begin tw_re = 16'sd23170;  tw_im = -16'sd23170; end
      2'd2: begin tw_re = 16'sd0;      tw_im = -16'sd32767; end
      2'd3: begin tw_re = -16'sd23170; tw_im = -16'sd23170; end
      default: ;
    endcase
  end

  typedef struct {
    int in_re [N];
    int in_im [N];
    int ex_re [N];
    int ex_im [N];
  } vec_t;

  vec_t vecs [4];
  int   checks = 0;
  int   passed = 0;
  int   st_seen [16];
  int   tw_seen [16];
  int   exp_st [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
  int   exp_tw [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int v, input bit gaps);
    for (int k = 0; k < N; k++) begin
      bit hs = 1'b0;
      int guard = 0;
      while (!hs && guard < 64) begin
        bus.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.in_re = bus.in_valid ? W'(vecs[v].in_re[k]) : 16'sh1234;
        bus.in_im = bus.in_valid ? W'(vecs[v].in_im[k]) : -16'sh0777;
        hs = bus.in_valid && bus.in_ready;
        step();
        guard++;
      end
      if (!hs) check($sformatf("v%0d load word %0d accepted", v, k), 0, 1);
    end
    bus.in_valid = 1'b0;
  endtask

  // Walk the compute phase; returns the number of busy cycles seen.
  task automatic compute(output int cyc, output int ovl);
    cyc = 0;
    ovl = 0;
    while (busy && cyc < 64) begin
      if (cyc < 16) begin
        st_seen[cyc] = int'(stage);
        tw_seen[cyc] = int'(tw_idx);
      end
      if (bus.in_ready || bus.out_valid) ovl++;
      cyc++;
      step();
    end
  endtask

  task automatic drain(input int v, input bit bp);
    for (int k = 0; k < N; k++) begin
      bit hs = 1'b0;
      int guard = 0;
      while (!hs && guard < 64) begin
        bit held;
        int hre, him;
        bus.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        if (bus.out_valid && bus.out_ready) begin
          check($sformatf("v%0d bin%0d re", v, k), int'(bus.out_re), vecs[v].ex_re[k]);
          check($sformatf("v%0d bin%0d im", v, k), int'(bus.out_im), vecs[v].ex_im[k]);
          check($sformatf("v%0d bin%0d last", v, k), int'(bus.out_last), int'(k == N - 1));
          hs = 1'b1;
        end
        held = bus.out_valid && !bus.out_ready;
        hre  = int'(bus.out_re);
        him  = int'(bus.out_im);
        step();
        guard++;
        if (held) begin
          check($sformatf("v%0d bin%0d stall valid", v, k), int'(bus.out_valid), 1);
          check($sformatf("v%0d bin%0d stall re", v, k), int'(bus.out_re), hre);
          check($sformatf("v%0d bin%0d stall im", v, k), int'(bus.out_im), him);
        end
      end
      if (!hs) check($sformatf("v%0d bin%0d output seen", v, k), 0, 1);
    end
    bus.out_ready = 1'b0;
    check($sformatf("v%0d in_ready after block", v), int'(bus.in_ready), 1);
    check($sformatf("v%0d out_valid after block", v), int'(bus.out_valid), 0);
  endtask

  task automatic run_block(input int v, input bit bp, input bit sched);
    int cyc, ovl, bad;
    load(v, bp);
    compute(cyc, ovl);
    check($sformatf("v%0d busy cycles", v), cyc, 12);
    check($sformatf("v%0d ready/valid during compute", v), ovl, 0);
    check($sformatf("v%0d out_valid after compute", v), int'(bus.out_valid), 1);
    if (sched) begin
      bad = 0;
      for (int c = 0; c < 12; c++) begin
        if (st_seen[c] != exp_st[c] || tw_seen[c] != exp_tw[c]) begin
          bad++;
          $display("FAIL twiddle schedule cycle %0d: got stage %0d tw %0d, expected %0d %0d",
                   c, st_seen[c], tw_seen[c], exp_st[c], exp_tw[c]);
        end
      end
      checks++;
      if (bad == 0) passed++;
    end
    drain(v, bp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    for (int v = 0; v < 4; v++) begin
      for (int k = 0; k < N; k++) begin
        vecs[v].in_re[k] = 0;
        vecs[v].in_im[k] = 0;
        vecs[v].ex_re[k] = 0;
        vecs[v].ex_im[k] = 0;
      end
    end
    // Impulse at bin-0 position: flat 1000/8.
    vecs[0].in_re[0] = 1000;
    vecs[0].ex_re    = '{125, 125, 125, 125, 125, 125, 125, 125};
    // DC.
    vecs[1].in_re    = '{800, 800, 800, 800, 800, 800, 800, 800};
    vecs[1].ex_re[0] = 800;
    // Alternating sign, already bit-reversed.
    vecs[2].in_re    = '{800, 800, 800, 800, -800, -800, -800, -800};
    vecs[2].ex_re[4] = 800;
    // Impulse at natural index 1 (bit-reversed slot 4): 125*W^k with truncation.
    vecs[3].in_re[4] = 1000;
    vecs[3].ex_re    = '{125, 88, 0, -89, -125, -88, 0, 88};
    vecs[3].ex_im    = '{0, -89, -125, -89, 0, 88, 125, 88};

    bus.in_valid  = 1'b0;
    bus.in_re     = '0;
    bus.in_im     = '0;
    bus.out_ready = 1'b0;

    #12;
    check("reset in_ready", int'(bus.in_ready), 0);
    check("reset busy", int'(busy), 0);
    check("reset out_valid", int'(bus.out_valid), 0);
    check("reset out_last", int'(bus.out_last), 0);
    check("reset out_re", int'(bus.out_re), 0);
    check("reset tw_idx", int'(tw_idx), 0);
    check("reset stage", int'(stage), 0);
    #10;
    rst_n = 1'b1;
    #1;
    check("in_ready before first edge", int'(bus.in_ready), 0);
    step();
    check("in_ready after release", int'(bus.in_ready), 1);

    for (int v = 0; v < 4; v++) run_block(v, 1'b0, v == 0);

    // Random stalls on both streams with the impulse block.
    run_block(0, 1'b1, 1'b0);

    // Abort in the middle of COMPUTE.
    load(1, 1'b0);
    cyc = 0;
    while (busy && cyc < 5) begin
      cyc++;
      step();
    end
    check("busy before abort", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort busy", int'(busy), 0);
    check("abort out_valid", int'(bus.out_valid), 0);
    check("abort in_ready", int'(bus.in_ready), 0);
    check("abort stage", int'(stage), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("in_ready after abort", int'(bus.in_ready), 1);
    run_block(1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
